ysyx_22040038_ifu: RTL and testbench

Parametrised instruction fetch unit that replaces the fixed PC-register fetch stage in the core top. It issues instruction-memory requests over a valid/ready channel with up to MAX_OUTSTANDING in flight, and buffers in-order responses in a DEPTH-entry instruction queue. It presents instruction/PC pairs to decode over a valid/ready handshake. A branch/jump redirect from EX flushes the queue and drops stale responses.

---
 rtl/ysyx_22040038_pkg.sv | 14 +
 rtl/ysyx_22040038_ifu_fifo.sv | 57 +++++
 rtl/ysyx_22040038_ifu.sv | 110 +++++++++++
 tb/tb_ysyx_22040038_ifu.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040038_pkg.sv
// Shared defaults and types for the instruction fetch unit.
package ysyx_22040038_pkg;

  localparam int          DEF_XLEN     = 64;
  localparam int          DEF_ILEN     = 32;
  localparam logic [63:0] DEF_RESET_PC = 64'h8000_0000;

  // One decoded-side queue entry: instruction word tagged with its fetch PC.
  typedef struct packed {
    logic [DEF_ILEN-1:0] inst;
    logic [DEF_XLEN-1:0] pc;
  } inst_pc_t;

endpackage

// File: rtl/ysyx_22040038_ifu_fifo.sv
// Small synchronous FIFO with flush. Head data is combinational from storage;
// callers gate it with their own valid (count != 0).
module ysyx_22040038_ifu_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_pop;
  logic             do_push;

  // Pointers wrap explicitly so non-power-of-two depths also work.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  // Occupancy and pointers; flush wins over any same-cycle push or pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      if (do_push) wr_ptr <= bump(wr_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Data storage needs no reset; it is never observed while empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ysyx_22040038_ifu.sv
// Instruction fetch unit: credit-limited request issue, in-order response
// tagging via an issued-PC FIFO, and a registered instruction queue to decode.
module ysyx_22040038_ifu
  import ysyx_22040038_pkg::*;
#(
  parameter int               XLEN            = DEF_XLEN,
  parameter int               ILEN            = DEF_ILEN,
  parameter int               DEPTH           = 4,
  parameter int               MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0]  RESET_PC        = DEF_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            rsp_valid,
  input  logic [ILEN-1:0] rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = ((CW > OW) ? CW : OW) + 1;
  localparam int QW = ILEN + XLEN;

  logic [XLEN-1:0] pc;
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   drop_cnt;
  logic [CW-1:0]   q_count;
  logic [QW-1:0]   q_head;
  logic [XLEN-1:0] rsp_pc;
  logic [SW-1:0]   used;
  logic            accept;
  logic            rsp_pop;
  logic            q_push;

  // Outstanding requests are exactly the entries of the issued-PC FIFO.
  assign rsp_pop = rsp_valid && (outstanding != '0);
  assign accept  = req_valid && req_ready;
  assign q_push  = rsp_pop && (drop_cnt == '0) && !redirect_valid;

  // Queue slots already spoken for: held entries plus live in-flight requests.
  assign used      = SW'(q_count) + SW'(outstanding) - SW'(drop_cnt);
  assign req_valid = rst && !redirect_valid
                     && (outstanding < OW'(MAX_OUTSTANDING))
                     && (used < SW'(DEPTH));
  assign req_addr  = pc;

  assign inst_valid = (q_count != '0);
  assign inst       = inst_valid ? q_head[QW-1:XLEN] : '0;
  assign inst_pc    = inst_valid ? q_head[XLEN-1:0]  : '0;

  // Fetch PC: redirect realigns to a word boundary, otherwise advance on accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_pc & ~XLEN'(3);
    end else if (accept) begin
      pc <= pc + XLEN'(4);
    end
  end

  // Stale-response counter: a redirect marks everything still in flight as
  // stale, minus a response landing in the same cycle (dropped right now).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      drop_cnt <= outstanding - OW'(rsp_pop);
    end else if (rsp_pop && (drop_cnt != '0)) begin
      drop_cnt <= drop_cnt - OW'(1);
    end
  end

  ysyx_22040038_ifu_fifo #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pc_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (accept),
    .push_data (pc),
    .pop       (rsp_pop),
    .head      (rsp_pc),
    .count     (outstanding)
  );

  ysyx_22040038_ifu_fifo #(
    .WIDTH (QW),
    .DEPTH (DEPTH)
  ) u_inst_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (q_push),
    .push_data ({rsp_data, rsp_pc}),
    .pop       (inst_valid && inst_ready),
    .head      (q_head),
    .count     (q_count)
  );

endmodule

// File: tb/tb_ysyx_22040038_ifu.sv
module tb_ysyx_22040038_ifu;
  import ysyx_22040038_pkg::*;

  localparam logic [63:0] RST_PC = 64'h8000_0000;
  localparam int MAXO = 2;
  localparam int QD   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [63:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  ysyx_22040038_ifu dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  // Memory model: accepted requests with the cycle their response is due.
  typedef struct {
    logic [63:0] addr;
    logic [63:0] exp_pc;
    int          due;
  } mem_t;

  mem_t        mem_q[$];
  bit          stl[$];      // per in-flight request: response will be stale
  inst_pc_t    mq[$];       // expected decode-side queue contents
  logic [63:0] model_pc;
  int          cyc;

  bit          d_ready, d_irdy, d_redir;
  logic [63:0] d_rpc;
  int          d_lat;
  int          pop_cnt;
  logic [63:0] last_pop_pc;
  bit          popped_flag;
  bit          found;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9bdf;
  endfunction

  function automatic bit rsp_due();
    return (mem_q.size() > 0) && (mem_q[0].due <= cyc);
  endfunction

  // One clock cycle: drive at negedge, check outputs, update model at posedge.
  task automatic step();
    bit acc, pv, rv;
    int live;
    bit exp_rv;
    mem_t m;
    bit s;
    @(negedge clk);
    rsp_valid      = rsp_due();
    rsp_data       = rsp_valid ? word_of(mem_q[0].addr) : 32'h0;
    req_ready      = d_ready;
    inst_ready     = d_irdy;
    redirect_valid = d_redir;
    redirect_pc    = d_rpc;
    #1;
    live = 0;
    foreach (stl[i]) if (!stl[i]) live++;
    exp_rv = !d_redir && (stl.size() < MAXO) && (mq.size() + live < QD);
    chk("req_valid", req_valid, exp_rv);
    chk("req_addr", req_addr, model_pc);
    chk("inst_valid", inst_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("inst", inst, mq[0].inst);
      chk("inst_pc", inst_pc, mq[0].pc);
    end
    acc = req_valid && req_ready;
    pv  = inst_valid && inst_ready;
    rv  = rsp_valid;
    @(posedge clk);
    if (pv && mq.size() > 0) begin
      pop_cnt++;
      popped_flag = 1'b1;
      last_pop_pc = mq[0].pc;
      void'(mq.pop_front());
    end
    if (rv && mem_q.size() > 0) begin
      m = mem_q.pop_front();
      s = stl.pop_front();
      if (!s && !d_redir) mq.push_back('{inst: word_of(m.exp_pc), pc: m.exp_pc});
    end
    if (d_redir) begin
      mq.delete();
      foreach (stl[i]) stl[i] = 1'b1;
      model_pc = {d_rpc[63:2], 2'b00};
    end
    if (acc) begin
      mem_q.push_back('{addr: req_addr, exp_pc: model_pc, due: cyc + d_lat});
      stl.push_back(1'b0);
      model_pc = model_pc + 64'd4;
    end
    chk("outstanding_max", stl.size() <= MAXO, 1'b1);
    cyc++;
  endtask

  initial begin
    rst = 1'b1;
    req_ready = 0; rsp_valid = 0; rsp_data = '0; inst_ready = 0;
    redirect_valid = 0; redirect_pc = '0;
    d_ready = 1; d_irdy = 1; d_redir = 0; d_rpc = '0; d_lat = 1;
    model_pc = RST_PC; cyc = 0; pop_cnt = 0; last_pop_pc = '0; popped_flag = 0;
    #1 rst = 1'b0;
    #1;
    chk("rst_req_valid", req_valid, 1'b0);
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_req_addr", req_addr, RST_PC);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 64'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Streaming: one instruction per cycle once the pipe is full.
    step();
    step();
    pop_cnt = 0;
    repeat (20) step();
    chk("throughput", pop_cnt, 20);

    // Decode stalls: queue fills and issue stops, then drains in order.
    d_irdy = 0;
    repeat (10) step();
    #1;
    chk("full_inst_valid", inst_valid, 1'b1);
    chk("full_req_valid", req_valid, 1'b0);
    d_irdy = 1;
    repeat (8) step();

    // Redirect with two requests in flight and no response that cycle.
    d_lat = 3;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (stl.size() == 2 && !rsp_due()) begin
        found = 1;
        d_redir = 1; d_rpc = 64'h8000_0101;
        step();
        d_redir = 0;
      end else begin
        step();
      end
    end
    chk("redir_found", found, 1'b1);
    #1;
    chk("redir_addr", req_addr, 64'h8000_0100);
    popped_flag = 0;
    for (int i = 0; i < 20 && !popped_flag; i++) step();
    chk("redir_popped", popped_flag, 1'b1);
    chk("redir_first_pc", last_pop_pc, 64'h8000_0100);

    // Redirect coinciding with a live response and an output pop.
    d_lat = 1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (rsp_due() && mq.size() > 0 && stl.size() > 0 && !stl[0]) begin
        found = 1;
        d_redir = 1; d_rpc = 64'h8000_2000;
        step();
        d_redir = 0;
      end else begin
        step();
      end
    end
    chk("same_cycle_found", found, 1'b1);
    #1;
    chk("same_cycle_flush", inst_valid, 1'b0);
    chk("same_cycle_addr", req_addr, 64'h8000_2000);
    repeat (6) step();

    // Random memory readiness, latency, decode stalls and redirects.
    for (int i = 0; i < 400; i++) begin
      d_ready = $urandom_range(0, 1) != 0;
      d_lat   = $urandom_range(1, 3);
      d_irdy  = $urandom_range(0, 3) != 0;
      d_redir = $urandom_range(0, 24) == 0;
      d_rpc   = {$urandom(), $urandom()};
      step();
    end
    d_redir = 0; d_ready = 1; d_irdy = 1; d_lat = 1;
    repeat (10) step();

    // Async reset with three entries queued.
    d_irdy = 0;
    for (int i = 0; i < 20 && mq.size() != 3; i++) step();
    chk("fill3", mq.size(), 3);
    #3 rst = 1'b0;
    #1;
    chk("midrst_inst_valid", inst_valid, 1'b0);
    chk("midrst_req_valid", req_valid, 1'b0);
    chk("midrst_req_addr", req_addr, RST_PC);
    chk("midrst_inst", inst, 32'h0);
    mem_q.delete(); stl.delete(); mq.delete();
    model_pc = RST_PC;
    rsp_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("post_rst_req_valid", req_valid, 1'b1);
    chk("post_rst_req_addr", req_addr, RST_PC);
    d_irdy = 1;
    repeat (12) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
